controle_pilha: RTL and testbench
=================================

# controle_pilha

Sequencer for the stack + ALU datapath (stack with push/pop, operand registers tmp1/tmp2 written by `load`, ALU output `s_ula`/`carryout`). It accepts host commands (push a byte, pop a byte, execute an opcode) and issues the single-cycle pop/load/push strobes in the correct order: pop two operands, latch them, capture the ALU result and push it back. It mirrors stack occupancy internally so that underflow and overflow are refused before any strobe is issued.

## Interface
- `DATA_W`, 8, datapath width
- `OPC_W`, 5, opcode width
- `DEPTH`, 8, stack depth, must match the datapath stack
- `clk`  in  1  clock, all state on rising edge
- `rstn`  in  1  reset, synchronous, active-low
- `start`  in  1  execute request, sampled in IDLE only
- `op_in`  in  OPC_W  opcode, captured with an accepted `start`
- `push_ext`  in  1  external push request, IDLE only
- `pop_ext`  in  1  external pop request, IDLE only
- `din_ext`  in  DATA_W  data for external push, captured with an accepted `push_ext`
- `s_ula`  in  DATA_W  ALU result from datapath
- `carryout`  in  1  ALU carry from datapath
- `pop`, `push`, `load`  out  1 each  datapath strobes
- `sel_tmp`  out  1  0 = `load` writes tmp1, 1 = tmp2
- `opcode`  out  OPC_W  registered opcode to ALU
- `din_pilha`  out  DATA_W  stack write data
- `nivel`  out  $clog2(DEPTH+1)  mirrored occupancy
- `busy`  out  1  command in progress
- `done`  out  1  one-cycle pulse at execute completion
- `result`  out  DATA_W  last captured ALU result
- `carry_flag`  out  1  last captured carry
- `err`  out  1  sticky error
- `err_code`  out  2  01 underflow, 10 overflow

## Operation
- States: IDLE, POP_A, LOAD_A, POP_B, LOAD_B, EXEC, PUSH_R, DONE, PUSH_E, POP_E, ERR.
- All strobes, `sel_tmp`, `busy` and `done` are decoded from the state register only. `din_pilha` is `result` in PUSH_R, else the captured push byte.
- IDLE priority: `start` > `push_ext` > `pop_ext`. Lower-priority requests in the same cycle are dropped.
- Execute with `nivel>=2`: capture `op_in` into `opcode`, then go to POP_A (`pop`), LOAD_A (`load`, `sel_tmp=0`), POP_B (`pop`), LOAD_B (`load`, `sel_tmp=1`), EXEC (capture `s_ula` into `result` and `carryout` into `carry_flag` at the end of the cycle), PUSH_R (`push`), DONE (`done`), then IDLE.
- Execute with `nivel<2`: go to ERR with code 01. No strobe is issued.
- `push_ext` with `nivel<DEPTH`: PUSH_E (`push`, `din_pilha`=captured byte), then IDLE. With `nivel==DEPTH`: ERR, code 10.
- `pop_ext` with `nivel>0`: POP_E (`pop`), then IDLE. With `nivel==0`: ERR, code 01.
- ERR: one cycle, `err` set, then IDLE. `err` and `err_code` hold until the next accepted command, which clears them.
- `nivel` changes +1 or -1 on each cycle in which `push` or `pop` is high. It never wraps. Execute leaves a net -1.
- Requests arriving outside IDLE are ignored, not queued.
- `busy=1` in every state except IDLE and DONE.

## Timing
- Reset (`rstn=0` at an edge): state IDLE. Every output is 0, including `opcode`, `result`, `nivel` and `err`.
- Reset mid-operation aborts on that edge with no further strobes. The datapath stack shares `rstn`, so `nivel=0` stays consistent.
- Execute: `start` accepted at edge k.
  - `pop` in cycles k+1 and k+3.
  - `load` in k+2 and k+4.
  - `result` valid from k+6.
  - `push` in k+6.
  - `done` in k+7.
  - Next command can be accepted at edge k+8.
- Datapath contract: stack read data is valid in the cycle after `pop`. The ALU is combinational from tmp1/tmp2 and is valid in EXEC.
- Operand order: first popped (the top of stack) goes to tmp1, second popped goes to tmp2.
- External push/pop: request accepted at edge k. The strobe is high in cycle k+1 only. IDLE again at k+2.
- At most one strobe is high in any cycle.

## Test plan
- Reset: hold `rstn=0` for 3 cycles with `start=1`. Required: every output is 0, no strobes, `nivel=0`.
- Push 12, then push 15, then `start` with `op_in=5'b00100`, using a bench ALU stub that computes tmp1+tmp2. Required: `nivel` goes 1, 2; tmp1=15, tmp2=12; `result=27`; `push` with `din_pilha=27` at k+6; `done` at k+7; `nivel=1`.
- Carry: push 200, then push 100, then execute with the add stub. Required: `result=44`, `carry_flag=1`.
- Underflow: from reset, push 7, then `start`. Required: no strobes, `err=1`, `err_code=01`, `nivel=1`. A following push of 3 clears `err`.
- Overflow: push `DEPTH` bytes, then one more push. Required: extra `push` strobe never asserted, `err_code=10`, `nivel=DEPTH`.
- Collisions: `start`+`push_ext` together in IDLE. Required: execute only. Then `push_ext` during POP_B is ignored. Then `rstn=0` in EXEC. Required: IDLE next cycle, no `push`, `nivel=0`.

Source files
------------

// File: rtl/controle_pilha.sv
// controle_pilha: sequencer for the stack + ALU datapath.
//
// Accepts three host commands while idle (execute opcode, push byte, pop
// byte). It issues the single-cycle pop/load/push strobes that move two
// operands from the stack into tmp1/tmp2, capture the ALU result and push it
// back. Stack occupancy is mirrored in `nivel`, so an underflow or overflow
// is refused before any strobe reaches the datapath.
//
// Ports
//   clk, rstn            clock, synchronous active-low reset
//   start, op_in         execute request and its opcode (IDLE only)
//   push_ext, din_ext    external push request and its byte (IDLE only)
//   pop_ext              external pop request (IDLE only)
//   s_ula, carryout      ALU result and carry from the datapath
//   pop, push, load      datapath strobes, at most one high per cycle
//   sel_tmp              0: load writes tmp1, 1: load writes tmp2
//   opcode               registered opcode driven to the ALU
//   din_pilha            stack write data
//   nivel                mirrored stack occupancy
//   busy, done           command in progress / execute completion pulse
//   result, carry_flag   last captured ALU result and carry
//   err, err_code        sticky error, 01 underflow, 10 overflow
module controle_pilha #(
  parameter  int DATA_W = 8,
  parameter  int OPC_W  = 5,
  parameter  int DEPTH  = 8,
  localparam int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [OPC_W-1:0]  op_in,
  input  logic              push_ext,
  input  logic              pop_ext,
  input  logic [DATA_W-1:0] din_ext,
  input  logic [DATA_W-1:0] s_ula,
  input  logic              carryout,
  output logic              pop,
  output logic              push,
  output logic              load,
  output logic              sel_tmp,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] din_pilha,
  output logic [LVL_W-1:0]  nivel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              carry_flag,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_POP_A  = 4'd1;
  localparam logic [3:0] S_LOAD_A = 4'd2;
  localparam logic [3:0] S_POP_B  = 4'd3;
  localparam logic [3:0] S_LOAD_B = 4'd4;
  localparam logic [3:0] S_EXEC   = 4'd5;
  localparam logic [3:0] S_PUSH_R = 4'd6;
  localparam logic [3:0] S_DONE   = 4'd7;
  localparam logic [3:0] S_PUSH_E = 4'd8;
  localparam logic [3:0] S_POP_E  = 4'd9;
  localparam logic [3:0] S_ERR    = 4'd10;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_UNDER = 2'b01;
  localparam logic [1:0] ERR_OVER  = 2'b10;

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] LVL_TWO  = LVL_W'(2);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  // Everything the datapath sees is a pure function of the state register,
  // so the strobes are glitch-free relative to the host inputs.
  typedef struct packed {
    logic pop;
    logic push;
    logic load;
    logic sel_tmp;
    logic busy;
    logic done;
  } strobe_t;

  logic [3:0]        st;
  logic [DATA_W-1:0] push_byte;
  strobe_t           stb;

  always_comb begin
    stb = '0;
    unique case (st)
      S_POP_A:  stb = '{pop: 1'b1, busy: 1'b1, default: 1'b0};
      S_LOAD_A: stb = '{load: 1'b1, busy: 1'b1, default: 1'b0};
      S_POP_B:  stb = '{pop: 1'b1, busy: 1'b1, default: 1'b0};
      S_LOAD_B: stb = '{load: 1'b1, sel_tmp: 1'b1, busy: 1'b1, default: 1'b0};
      S_EXEC:   stb = '{busy: 1'b1, default: 1'b0};
      S_PUSH_R: stb = '{push: 1'b1, busy: 1'b1, default: 1'b0};
      S_DONE:   stb = '{done: 1'b1, default: 1'b0};
      S_PUSH_E: stb = '{push: 1'b1, busy: 1'b1, default: 1'b0};
      S_POP_E:  stb = '{pop: 1'b1, busy: 1'b1, default: 1'b0};
      S_ERR:    stb = '{busy: 1'b1, default: 1'b0};
      default:  stb = '0;
    endcase
  end

  assign pop     = stb.pop;
  assign push    = stb.push;
  assign load    = stb.load;
  assign sel_tmp = stb.sel_tmp;
  assign busy    = stb.busy;
  assign done    = stb.done;

  // Only PUSH_R writes the ALU result; every other push is the host byte.
  assign din_pilha = (st == S_PUSH_R) ? result : push_byte;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      st         <= S_IDLE;
      opcode     <= '0;
      push_byte  <= '0;
      nivel      <= '0;
      result     <= '0;
      carry_flag <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      // Occupancy mirror. The state checks below already keep push/pop in
      // range; the guards only stop a corrupted state from wrapping it.
      if (stb.push && nivel != LVL_FULL)
        nivel <= nivel + LVL_ONE;
      else if (stb.pop && nivel != '0)
        nivel <= nivel - LVL_ONE;

      unique case (st)
        S_IDLE: begin
          // Fixed priority; a lower-priority request in the same cycle is
          // dropped rather than held.
          if (start) begin
            opcode <= op_in;
            if (nivel >= LVL_TWO) begin
              st       <= S_POP_A;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end else begin
              st       <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_UNDER;
            end
          end else if (push_ext) begin
            push_byte <= din_ext;
            if (nivel != LVL_FULL) begin
              st       <= S_PUSH_E;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end else begin
              st       <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_OVER;
            end
          end else if (pop_ext) begin
            if (nivel != '0) begin
              st       <= S_POP_E;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end else begin
              st       <= S_ERR;
              err      <= 1'b1;
              err_code <= ERR_UNDER;
            end
          end
        end
        S_POP_A:  st <= S_LOAD_A;
        S_LOAD_A: st <= S_POP_B;
        S_POP_B:  st <= S_LOAD_B;
        S_LOAD_B: st <= S_EXEC;
        S_EXEC: begin
          // tmp1/tmp2 are both loaded by now, so the combinational ALU
          // output is settled in this cycle.
          result     <= s_ula;
          carry_flag <= carryout;
          st         <= S_PUSH_R;
        end
        S_PUSH_R: st <= S_DONE;
        default:  st <= S_IDLE;  // DONE, PUSH_E, POP_E, ERR and unused codes
      endcase
    end
  end

endmodule

// File: tb/tb_controle_pilha.sv
// Bench for controle_pilha: stack/ALU stub datapath, a queue-based model of
// the stack that predicts every output cycle by cycle, and a few literal
// expectations computed by hand.
module tb_controle_pilha;
  localparam int DW = 8;
  localparam int OW = 5;
  localparam int D  = 8;
  localparam int LW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, push_ext = 1'b0, pop_ext = 1'b0;
  logic [OW-1:0] op_in = '0;
  logic [DW-1:0] din_ext = '0;
  logic [DW-1:0] s_ula;
  logic          carryout;
  logic          pop, push, load, sel_tmp, busy, done, carry_flag, err;
  logic [OW-1:0] opcode;
  logic [DW-1:0] din_pilha, result;
  logic [LW-1:0] nivel;
  logic [1:0]    err_code;

  controle_pilha #(.DATA_W(DW), .OPC_W(OW), .DEPTH(D)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op_in(op_in),
    .push_ext(push_ext), .pop_ext(pop_ext), .din_ext(din_ext),
    .s_ula(s_ula), .carryout(carryout),
    .pop(pop), .push(push), .load(load), .sel_tmp(sel_tmp),
    .opcode(opcode), .din_pilha(din_pilha), .nivel(nivel),
    .busy(busy), .done(done), .result(result), .carry_flag(carry_flag),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- stub datapath: stack, tmp registers, adder ALU
  logic [DW-1:0] mem [D];
  int            sp = 0;
  logic [DW-1:0] rd = '0, tmp1 = '0, tmp2 = '0;

  always @(posedge clk) begin
    if (!rstn) begin
      sp <= 0; rd <= '0; tmp1 <= '0; tmp2 <= '0;
    end else begin
      if (push && sp < D) begin
        mem[sp] <= din_pilha;
        sp <= sp + 1;
      end else if (pop && sp > 0) begin
        rd <= mem[sp-1];
        sp <= sp - 1;
      end
      if (load) begin
        if (sel_tmp) tmp2 <= rd;
        else         tmp1 <= rd;
      end
    end
  end

  assign {carryout, s_ula} = {1'b0, tmp1} + {1'b0, tmp2};

  // ---------------- behavioural model
  typedef struct {
    logic          pop, push, load, sel_tmp, busy, done;
    logic [OW-1:0] opcode;
    logic [DW-1:0] din, result;
    logic          carry;
    logic [LW-1:0] nivel;
    logic          err;
    logic [1:0]    code;
  } frame_t;

  logic [DW-1:0] mq[$];          // model stack, back = top
  logic [OW-1:0] m_opc;
  logic [DW-1:0] m_byte, m_res;
  logic          m_cy, m_err;
  logic [1:0]    m_code;

  frame_t exp_at[int];           // expected outputs of busy cycles, by cycle
  frame_t cur_idle, next_idle;   // expected outputs of idle cycles
  int     next_from = 0;
  bit     chk_en = 1'b0;

  int n_push = 0, n_pop = 0, n_load = 0;
  int last_push_cyc = -1, last_done_cyc = -1;
  logic [DW-1:0] last_push_din = '0;

  function automatic frame_t idle_frm();
    frame_t f;
    f.pop = 1'b0; f.push = 1'b0; f.load = 1'b0; f.sel_tmp = 1'b0;
    f.busy = 1'b0; f.done = 1'b0;
    f.opcode = m_opc; f.din = m_byte; f.result = m_res; f.carry = m_cy;
    f.nivel = LW'(mq.size()); f.err = m_err; f.code = m_code;
    return f;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_opc = '0; m_byte = '0; m_res = '0; m_cy = 1'b0; m_err = 1'b0; m_code = 2'b00;
  endtask

  // Freeze the expectation for the current (still idle) cycle before the
  // model is advanced for a new command.
  task automatic begin_cmd();
    if (cyc >= next_from) cur_idle = next_idle;
    if (!exp_at.exists(cyc)) exp_at[cyc] = cur_idle;
  endtask

  // ---------------- per-cycle compare
  always @(negedge clk) begin
    if (chk_en) begin
      frame_t e;
      if (cyc >= next_from) cur_idle = next_idle;
      e = exp_at.exists(cyc) ? exp_at[cyc] : cur_idle;
      chk($sformatf("c%0d_pop", cyc),        pop,        e.pop);
      chk($sformatf("c%0d_push", cyc),       push,       e.push);
      chk($sformatf("c%0d_load", cyc),       load,       e.load);
      chk($sformatf("c%0d_sel_tmp", cyc),    sel_tmp,    e.sel_tmp);
      chk($sformatf("c%0d_busy", cyc),       busy,       e.busy);
      chk($sformatf("c%0d_done", cyc),       done,       e.done);
      chk($sformatf("c%0d_opcode", cyc),     opcode,     e.opcode);
      chk($sformatf("c%0d_din_pilha", cyc),  din_pilha,  e.din);
      chk($sformatf("c%0d_nivel", cyc),      nivel,      e.nivel);
      chk($sformatf("c%0d_result", cyc),     result,     e.result);
      chk($sformatf("c%0d_carry_flag", cyc), carry_flag, e.carry);
      chk($sformatf("c%0d_err", cyc),        err,        e.err);
      chk($sformatf("c%0d_err_code", cyc),   err_code,   e.code);
      if (push === 1'b1) begin
        n_push++; last_push_cyc = cyc; last_push_din = din_pilha;
      end
      if (pop === 1'b1)  n_pop++;
      if (load === 1'b1) n_load++;
      if (done === 1'b1) last_done_cyc = cyc;
    end
  end

  // ---------------- drivers (all run at posedge + 1)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_now();
    frame_t keep;
    begin_cmd();
    keep = exp_at[cyc];
    exp_at.delete();
    exp_at[cyc] = keep;
    rstn = 1'b0;
    model_reset();
    next_idle = idle_frm();
    next_from = cyc + 1;
  endtask

  task automatic do_reset(input int n);
    reset_now();
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  task automatic cmd_push(input logic [DW-1:0] d);
    int c = cyc;
    frame_t f;
    begin_cmd();
    push_ext = 1'b1; din_ext = d;
    m_byte = d;
    if (mq.size() < D) begin
      m_err = 1'b0; m_code = 2'b00;
      f = idle_frm(); f.busy = 1'b1; f.push = 1'b1;
      exp_at[c+1] = f;
      mq.push_back(d);
    end else begin
      m_err = 1'b1; m_code = 2'b10;
      f = idle_frm(); f.busy = 1'b1;
      exp_at[c+1] = f;
    end
    next_idle = idle_frm(); next_from = c + 2;
    tick(); push_ext = 1'b0;
    tick();
  endtask

  // inj_rel: cycle (relative to acceptance) where a stray push_ext is driven
  // rst_rel: cycle where rstn is pulled low; -1 disables either
  task automatic cmd_exec(input logic [OW-1:0] op, input bit with_push,
                          input int inj_rel, input int rst_rel, output int c0);
    int c = cyc;
    int n, L;
    frame_t f;
    logic [DW-1:0] a, b;
    logic [DW:0] sum;
    c0 = c;
    begin_cmd();
    start = 1'b1; op_in = op;
    if (with_push) begin push_ext = 1'b1; din_ext = 8'd99; end
    L = mq.size();
    m_opc = op;
    if (L >= 2) begin
      m_err = 1'b0; m_code = 2'b00;
      a = mq[$]; b = mq[$-1];
      f = idle_frm(); f.busy = 1'b1;
      f.pop = 1'b1;                                   f.nivel = LW'(L);   exp_at[c+1] = f;
      f.pop = 1'b0; f.load = 1'b1;                    f.nivel = LW'(L-1); exp_at[c+2] = f;
      f.load = 1'b0; f.pop = 1'b1;                                        exp_at[c+3] = f;
      f.pop = 1'b0; f.load = 1'b1; f.sel_tmp = 1'b1;  f.nivel = LW'(L-2); exp_at[c+4] = f;
      f.load = 1'b0; f.sel_tmp = 1'b0;                                    exp_at[c+5] = f;
      sum = {1'b0, a} + {1'b0, b};
      m_res = sum[DW-1:0]; m_cy = sum[DW];
      void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(m_res);
      f.result = m_res; f.carry = m_cy; f.push = 1'b1; f.din = m_res;     exp_at[c+6] = f;
      f = idle_frm(); f.done = 1'b1;                                      exp_at[c+7] = f;
      n = 8;
    end else begin
      m_err = 1'b1; m_code = 2'b01;
      f = idle_frm(); f.busy = 1'b1; exp_at[c+1] = f;
      n = 2;
    end
    next_idle = idle_frm(); next_from = c + n;
    for (int i = 1; i <= n; i++) begin
      tick();
      start = 1'b0; push_ext = 1'b0;
      if (i == inj_rel) begin push_ext = 1'b1; din_ext = 8'd77; end
      if (i == rst_rel) begin
        do_reset(1);
        break;
      end
    end
    push_ext = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int c, sp0, sl0, sd0;
    // Reset held for three edges with start asserted.
    rstn = 1'b0; start = 1'b1; op_in = 5'b11111;
    tick();
    model_reset();
    cur_idle = idle_frm(); next_idle = cur_idle; next_from = 0;
    chk_en = 1'b1;
    repeat (2) tick();
    chk("rst_nivel", nivel, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_result", result, 0);
    chk("rst_err", err, 0);
    chk("rst_strobes", n_push + n_pop + n_load, 0);
    rstn = 1'b1; start = 1'b0; op_in = '0;
    tick();

    // Basic execute: 12, 15, add.
    cmd_push(8'd12); chk("lvl_after_12", nivel, 1);
    cmd_push(8'd15); chk("lvl_after_15", nivel, 2);
    cmd_exec(5'b00100, 1'b0, -1, -1, c);
    chk("add_tmp1", tmp1, 15);
    chk("add_tmp2", tmp2, 12);
    chk("add_result", result, 27);
    chk("add_carry", carry_flag, 0);
    chk("add_push_cyc", last_push_cyc - c, 6);
    chk("add_push_din", last_push_din, 27);
    chk("add_done_cyc", last_done_cyc - c, 7);
    chk("add_nivel", nivel, 1);

    // Carry out of the adder.
    cmd_push(8'd200); cmd_push(8'd100);
    cmd_exec(5'b00100, 1'b0, -1, -1, c);
    chk("cy_result", result, 44);
    chk("cy_flag", carry_flag, 1);
    chk("cy_nivel", nivel, 2);

    // Underflow, then cleared by a good push.
    do_reset(1); tick();
    cmd_push(8'd7);
    sp0 = n_push; sl0 = n_pop; sd0 = n_load;
    cmd_exec(5'b00001, 1'b0, -1, -1, c);
    chk("uf_strobes", (n_push - sp0) + (n_pop - sl0) + (n_load - sd0), 0);
    chk("uf_err", err, 1);
    chk("uf_code", err_code, 2'b01);
    chk("uf_nivel", nivel, 1);
    cmd_push(8'd3);
    chk("uf_clear_err", err, 0);
    chk("uf_clear_nivel", nivel, 2);

    // Overflow.
    do_reset(1); tick();
    for (int i = 0; i < D; i++) cmd_push(8'(i + 1));
    chk("of_full", nivel, D);
    sp0 = n_push;
    cmd_push(8'd9);
    chk("of_no_push", n_push - sp0, 0);
    chk("of_code", err_code, 2'b10);
    chk("of_err", err, 1);
    chk("of_nivel", nivel, D);

    // Collisions: start+push_ext, push_ext during POP_B, reset in EXEC.
    do_reset(1); tick();
    cmd_push(8'd5); cmd_push(8'd6);
    sp0 = n_push; sl0 = n_pop;
    cmd_exec(5'b00010, 1'b1, 3, 5, c);
    chk("col_pops", n_pop - sl0, 2);
    chk("col_no_push", n_push - sp0, 0);
    chk("col_nivel", nivel, 0);
    chk("col_busy", busy, 0);
    repeat (2) tick();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
